// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl
// Sequencing controller for an N x N systolic array of MAC/ReLU PE tiles.
// A start command clears the PE accumulators, streams k_len operand vectors
// from the shared-address A/B buffers, skews them diagonally onto the array's
// west (rows) and north (columns) edges, waits 2N cycles for the wavefront to
// drain and then pulses done.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   start         in   single-cycle job request, honoured only in IDLE
//   k_len         in   inner dimension, latched with start (saturates to K_MAX)
//   abort         in   synchronous abort of the running job
//   busy          out  high in every state except IDLE
//   done          out  one-cycle completion pulse
//   pe_clear      out  one-cycle accumulator clear for all PEs
//   rd_en         out  read enable to the A and B buffers
//   rd_addr       out  shared buffer read address (data returns 1 cycle later)
//   a_rd_data     in   A row vector, row i in slice i
//   b_rd_data     in   B column vector, column j in slice j
//   a_edge        out  skewed west-edge operands, row i delayed i cycles
//   b_edge        out  skewed north-edge operands, column j delayed j cycles
//   a_edge_valid  out  per-row valid for the column-0 PEs
//   b_edge_valid  out  per-column valid for the row-0 PEs
//   perf_cycles   out  busy-cycle count of the latest job (only when the
//                      SYSTOLIC_SEQ_PERF_EN macro is defined)
module systolic_seq_ctrl #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int K_MAX      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(K_MAX+1)-1:0]    k_len,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          pe_clear,
    output logic                          rd_en,
    output logic [$clog2(K_MAX)-1:0]      rd_addr,
    input  logic [N*DATA_WIDTH-1:0]       a_rd_data,
    input  logic [N*DATA_WIDTH-1:0]       b_rd_data,
    output logic [N*DATA_WIDTH-1:0]       a_edge,
    output logic [N*DATA_WIDTH-1:0]       b_edge,
    output logic [N-1:0]                  a_edge_valid,
    output logic [N-1:0]                  b_edge_valid
`ifdef SYSTOLIC_SEQ_PERF_EN
    ,
    output logic [31:0]                   perf_cycles
`endif
);

    localparam int K_W = $clog2(K_MAX + 1);
    localparam int A_W = $clog2(K_MAX);
    localparam int D_W = $clog2(2 * N);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic [K_W-1:0]   k_reg;
    logic [K_W-1:0]   k_sat;
    logic [D_W-1:0]   drain_cnt;
    logic             last_feed;
    logic             last_drain;
    logic             accept;
    logic             flush;
    logic             rd_valid_d;

    assign k_sat      = (k_len > K_W'(K_MAX)) ? K_W'(K_MAX) : k_len;
    assign last_feed  = (K_W'(rd_addr) == (k_reg - K_W'(1)));
    assign last_drain = (drain_cnt == D_W'(2 * N - 1));
    assign accept     = (state == IDLE) && (next_state == CLEAR);
    // Abort only matters while a job is running; it also empties the skew lanes.
    assign flush      = abort && (state != IDLE);

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign pe_clear = (state == CLEAR);
    assign rd_en    = (state == FEED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state. Abort overrides every other transition, including a start
    // arriving in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && !abort && (k_len != '0)) next_state = CLEAR;
            CLEAR:   next_state = FEED;
            FEED:    if (last_feed) next_state = DRAIN;
            DRAIN:   if (last_drain) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) begin
            next_state = IDLE;
        end
    end

    // Job length, buffer address and drain counters. The counters only advance
    // while their state persists, so they are already 0 on entry to FEED/DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_reg     <= '0;
            rd_addr   <= '0;
            drain_cnt <= '0;
        end else begin
            if (accept) begin
                k_reg <= k_sat;
            end
            rd_addr   <= (state == FEED && next_state == FEED) ? rd_addr + A_W'(1) : '0;
            drain_cnt <= (state == DRAIN && next_state == DRAIN) ? drain_cnt + D_W'(1) : '0;
        end
    end

    // Buffer data arrives one cycle after the read, so the read-return valid
    // is rd_en delayed by one register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_d <= 1'b0;
        end else if (flush) begin
            rd_valid_d <= 1'b0;
        end else begin
            rd_valid_d <= rd_en;
        end
    end

    // Diagonal skew. Lane 0 passes the returned data straight through; lane i
    // runs it through an i-deep shift register. Data is zeroed on entry when
    // invalid so idle lanes present 0.
    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == 0) begin : g_direct
            assign a_edge_valid[0]         = rd_valid_d;
            assign b_edge_valid[0]         = rd_valid_d;
            assign a_edge[0 +: DATA_WIDTH] = rd_valid_d ? a_rd_data[0 +: DATA_WIDTH] : '0;
            assign b_edge[0 +: DATA_WIDTH] = rd_valid_d ? b_rd_data[0 +: DATA_WIDTH] : '0;
        end else begin : g_skew
            logic                  vld_sr [i];
            logic [DATA_WIDTH-1:0] a_sr   [i];
            logic [DATA_WIDTH-1:0] b_sr   [i];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int s = 0; s < i; s++) begin
                        vld_sr[s] <= 1'b0;
                        a_sr[s]   <= '0;
                        b_sr[s]   <= '0;
                    end
                end else if (flush) begin
                    for (int s = 0; s < i; s++) begin
                        vld_sr[s] <= 1'b0;
                        a_sr[s]   <= '0;
                        b_sr[s]   <= '0;
                    end
                end else begin
                    vld_sr[0] <= rd_valid_d;
                    a_sr[0]   <= rd_valid_d ? a_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                    b_sr[0]   <= rd_valid_d ? b_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                    for (int s = 1; s < i; s++) begin
                        vld_sr[s] <= vld_sr[s-1];
                        a_sr[s]   <= a_sr[s-1];
                        b_sr[s]   <= b_sr[s-1];
                    end
                end
            end

            assign a_edge_valid[i]                  = vld_sr[i-1];
            assign b_edge_valid[i]                  = vld_sr[i-1];
            assign a_edge[i*DATA_WIDTH +: DATA_WIDTH] = vld_sr[i-1] ? a_sr[i-1] : '0;
            assign b_edge[i*DATA_WIDTH +: DATA_WIDTH] = vld_sr[i-1] ? b_sr[i-1] : '0;
        end
    end

`ifdef SYSTOLIC_SEQ_PERF_EN
    // Busy-cycle counter: zeroed when a job is accepted, then counts every
    // non-IDLE cycle and holds once the job ends (done or abort).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles <= '0;
        end else if (accept) begin
            perf_cycles <= '0;
        end else if (busy) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl
// Scoreboard bench for systolic_seq_ctrl (N=4, DATA_WIDTH=16, K_MAX=16).
// applyStimulus issues a job and pushes the expected pe_clear, read, edge and
// done events (with their cycle numbers) into queues; an independent monitor
// pops and compares whenever the DUT raises the matching strobe.
// Cycle numbering: cycle m is the clock period that ends at rising edge m.
module tb_systolic_seq_ctrl;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int K_MAX = 16;

    logic              clk;
    logic              rst;
    logic              start;
    logic [4:0]        k_len;
    logic              abort;
    logic              busy;
    logic              done;
    logic              pe_clear;
    logic              rd_en;
    logic [3:0]        rd_addr;
    logic [N*DW-1:0]   a_rd_data;
    logic [N*DW-1:0]   b_rd_data;
    logic [N*DW-1:0]   a_edge;
    logic [N*DW-1:0]   b_edge;
    logic [N-1:0]      a_edge_valid;
    logic [N-1:0]      b_edge_valid;
`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0]       perf_cycles;
`endif

    systolic_seq_ctrl #(.N(N), .DATA_WIDTH(DW), .K_MAX(K_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .k_len        (k_len),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .pe_clear     (pe_clear),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .a_rd_data    (a_rd_data),
        .b_rd_data    (b_rd_data),
        .a_edge       (a_edge),
        .b_edge       (b_edge),
        .a_edge_valid (a_edge_valid),
        .b_edge_valid (b_edge_valid)
`ifdef SYSTOLIC_SEQ_PERF_EN
        ,
        .perf_cycles  (perf_cycles)
`endif
    );

    typedef struct {
        int cyc;
        int addr;
    } rd_ev_t;

    typedef struct {
        int          cyc;
        int          lane;
        logic [15:0] a;
        logic [15:0] b;
    } edge_ev_t;

    int       clr_q[$];
    int       done_q[$];
    rd_ev_t   rd_q[$];
    edge_ev_t edge_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int now();
        return cyc + 1;
    endfunction

    // Buffer contents: distinct per address and per lane so skew mistakes show.
    function automatic logic [15:0] aval(int a, int i);
        return 16'(256 * (i + 1) + a + 1);
    endfunction

    function automatic logic [15:0] bval(int a, int j);
        return 16'(16'h4000 + 16 * j + a);
    endfunction

    // Buffer model: one-cycle read latency, junk on idle cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_rd_data <= '0;
            b_rd_data <= '0;
        end else if (rd_en) begin
            for (int i = 0; i < N; i++) begin
                a_rd_data[i*DW +: DW] <= aval(int'(rd_addr), i);
                b_rd_data[i*DW +: DW] <= bval(int'(rd_addr), i);
            end
        end else begin
            a_rd_data <= {N{16'hDEAD}};
            b_rd_data <= {N{16'hBEEF}};
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, now(), actual, expected);
        end
    endtask

    // Monitor: compares every strobe the DUT raises against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (pe_clear) begin
                checkOutput("pe_clear_expected", clr_q.size() > 0, 1);
                if (clr_q.size() > 0) checkOutput("pe_clear_cycle", now(), clr_q.pop_front());
            end
            if (rd_en) begin
                checkOutput("rd_en_expected", rd_q.size() > 0, 1);
                if (rd_q.size() > 0) begin
                    rd_ev_t ev;
                    ev = rd_q.pop_front();
                    checkOutput("rd_en_cycle", now(), ev.cyc);
                    checkOutput("rd_addr", rd_addr, ev.addr);
                end
            end
            if (done) begin
                checkOutput("done_expected", done_q.size() > 0, 1);
                if (done_q.size() > 0) checkOutput("done_cycle", now(), done_q.pop_front());
            end
            for (int i = 0; i < N; i++) begin
                if (a_edge_valid[i] || b_edge_valid[i]) begin
                    checkOutput("edge_expected", edge_q.size() > 0, 1);
                    if (edge_q.size() > 0) begin
                        edge_ev_t ev;
                        ev = edge_q.pop_front();
                        checkOutput("edge_cycle", now(), ev.cyc);
                        checkOutput("edge_lane", i, ev.lane);
                        checkOutput("a_edge_valid", a_edge_valid[i], 1);
                        checkOutput("b_edge_valid", b_edge_valid[i], 1);
                        checkOutput("a_edge_data", a_edge[i*DW +: DW], ev.a);
                        checkOutput("b_edge_data", b_edge[i*DW +: DW], ev.b);
                    end
                end else begin
                    checkOutput("a_edge_idle_zero", a_edge[i*DW +: DW], 0);
                    checkOutput("b_edge_idle_zero", b_edge[i*DW +: DW], 0);
                end
            end
        end
    end

    // Drive one start pulse and record what the job should produce. Events at
    // or after cycle offset lim are not expected (used for the abort case).
    task automatic applyStimulus(input int k, input int lim);
        int t0;
        int keff;
        t0    = now();
        start = 1'b1;
        k_len = 5'(k);
        keff  = (k > K_MAX) ? K_MAX : k;
        if (keff > 0) begin
            if (1 < lim) clr_q.push_back(t0 + 1);
            for (int a = 0; a < keff; a++) begin
                if (2 + a < lim) rd_q.push_back('{cyc: t0 + 2 + a, addr: a});
            end
            if (2 + keff + 2 * N < lim) done_q.push_back(t0 + 2 + keff + 2 * N);
            for (int c = 3; c <= 2 + keff + N - 1; c++) begin
                if (c < lim) begin
                    for (int i = 0; i < N; i++) begin
                        int a;
                        a = c - 3 - i;
                        if (a >= 0 && a < keff)
                            edge_q.push_back('{cyc: t0 + c, lane: i, a: aval(a, i), b: bval(a, i)});
                    end
                end
            end
        end
        @(posedge clk) #1;
        start = 1'b0;
        k_len = '0;
    endtask

    task automatic waitDone(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput("done_within_budget", seen, 1);
    endtask

    task automatic checkIdleOutputs();
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_done", done, 0);
        checkOutput("idle_pe_clear", pe_clear, 0);
        checkOutput("idle_rd_en", rd_en, 0);
        checkOutput("idle_rd_addr", rd_addr, 0);
        checkOutput("idle_a_edge", a_edge, 0);
        checkOutput("idle_b_edge", b_edge, 0);
        checkOutput("idle_a_edge_valid", a_edge_valid, 0);
        checkOutput("idle_b_edge_valid", b_edge_valid, 0);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        k_len = '0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkIdleOutputs();
        rst = 1'b1;
        @(posedge clk) #1;

        $display("[TB] job k_len=3");
        applyStimulus(3, 1000);
        waitDone(100);
`ifdef SYSTOLIC_SEQ_PERF_EN
        @(posedge clk) #1;
        checkOutput("perf_cycles", perf_cycles, 13);
`endif

        $display("[TB] start with k_len=0 is ignored");
        @(posedge clk) #1;
        applyStimulus(0, 1000);
        checkOutput("busy_after_k0", busy, 0);
        repeat (3) begin
            @(posedge clk) #1;
            checkOutput("busy_stays_low_k0", busy, 0);
        end

        $display("[TB] k_len=20 saturates, start during DRAIN ignored");
        applyStimulus(20, 1000);
        repeat (20) @(posedge clk) #1;
        start = 1'b1;
        k_len = 5'd3;
        @(posedge clk) #1;
        start = 1'b0;
        k_len = '0;
        checkOutput("busy_in_drain", busy, 1);
        waitDone(100);

        $display("[TB] back-to-back job");
        @(posedge clk) #1;
        applyStimulus(2, 1000);
        waitDone(100);

        $display("[TB] abort in second FEED cycle");
        @(posedge clk) #1;
        applyStimulus(5, 4);
        @(posedge clk) #1;
        @(posedge clk) #1;
        abort = 1'b1;
        @(posedge clk) #1;
        abort = 1'b0;
        checkOutput("busy_after_abort", busy, 0);
        checkOutput("a_valid_after_abort", a_edge_valid, 0);
        checkOutput("b_valid_after_abort", b_edge_valid, 0);
        applyStimulus(2, 1000);
        waitDone(100);

        repeat (4) @(posedge clk) #1;
        checkOutput("clr_q_empty", clr_q.size(), 0);
        checkOutput("rd_q_empty", rd_q.size(), 0);
        checkOutput("done_q_empty", done_q.size(), 0);
        checkOutput("edge_q_empty", edge_q.size(), 0);

        $display("[TB] asynchronous reset mid-FEED");
        applyStimulus(8, 1000);
        repeat (3) @(posedge clk);
        #3;
        checkOutput("busy_before_reset", busy, 1);
        rst = 1'b0;
        clr_q.delete();
        rd_q.delete();
        done_q.delete();
        edge_q.delete();
        #1;
        checkIdleOutputs();
        @(posedge clk) #3;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk) #1;
            checkOutput("busy_after_reset", busy, 0);
            checkOutput("rd_en_after_reset", rd_en, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_seq_ctrl.md
# systolic_seq_ctrl

Sequencing controller for an N×N systolic array of PE tiles (multiply-accumulate with ReLU output). On a start command it clears the PE accumulators, streams K operand vectors from the A (row) and B (column) operand buffers, and applies the diagonal skew the array needs. It then waits for the wavefront to drain and signals completion so the result grid can be read. It sits between the operand buffers and the array's west and north edges.

## Interface
- `N`, 4: array dimension (rows = columns = N), N ≥ 2
- `DATA_WIDTH`, 16: operand width, equal to the PE `DATA_WIDTH`
- `K_MAX`, 16: maximum inner dimension. Buffer address width is `$clog2(K_MAX)`.

- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: single-cycle request; sampled only in IDLE
- `k_len` in `$clog2(K_MAX+1)`: inner dimension, sampled with `start`
- `abort` in 1: synchronous abort of the current job
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse when the job completes
- `pe_clear` out 1: one-cycle accumulator clear for all PEs
- `rd_en` out 1: read enable to the A and B buffers (shared address)
- `rd_addr` out `$clog2(K_MAX)`: read address; the buffers return data 1 cycle later
- `a_rd_data` in `N*DATA_WIDTH`: row vector; row i is at slice i
- `b_rd_data` in `N*DATA_WIDTH`: column vector; column j is at slice j
- `a_edge` out `N*DATA_WIDTH`: skewed west-edge operands to PE rows
- `b_edge` out `N*DATA_WIDTH`: skewed north-edge operands to PE columns
- `a_edge_valid` out N: per-row `valid_in` for column-0 PEs
- `b_edge_valid` out N: per-column `valid_in` for row-0 PEs

## Operation
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - `start`=1 with `k_len`≠0 → CLEAR. `k_len` is latched; values above K_MAX saturate to K_MAX.
  - `start` with `k_len`=0 is ignored.
- CLEAR (1 cycle): `pe_clear`=1 → FEED.
- FEED (exactly k_len cycles): `rd_en`=1, `rd_addr` = 0,1,…,k_len−1. The last cycle → DRAIN.
- DRAIN (exactly 2N cycles): `rd_en`=0; the skew pipeline empties → DONE.
- DONE (1 cycle): `done`=1 → IDLE.
- Skew:
  - The read-return valid is `rd_en` delayed 1 cycle.
  - Row i data and valid are delayed a further i cycles. Column j data and valid are delayed a further j cycles.
  - Row 0 and column 0 have zero extra delay.
- An edge lane whose valid is 0 drives data 0.
- `abort`:
  - In any non-IDLE state, `abort` → IDLE on the next edge.
  - All skew valids are flushed to 0 and `done` is not pulsed.
  - `abort` in IDLE has no effect. `abort` wins over `start` in the same cycle.
- `start` while `busy` is ignored; it is not queued.

## Timing
- Reset values: state IDLE. `busy`, `done`, `pe_clear`, `rd_en` = 0. `rd_addr` = 0. All edge data and valids = 0. All skew registers = 0.
- Job starting with `start` sampled at edge T0:
  - `pe_clear` is high in cycle T0+1.
  - `rd_en` is high in cycles T0+2 … T0+1+k_len.
  - `a_edge_valid[i]` is high in cycles T0+3+i … T0+2+i+k_len; `b_edge_valid[j]` follows the same pattern with j.
  - `done` is high in cycle T0+2+k_len+2N.
  - `busy` is high from T0+1 through the `done` cycle inclusive.
- Earliest next accepted `start` is the cycle after `done`, i.e. back-to-back jobs are allowed.
- The result is stable at `done`: PE(N−1,N−1) receives its last operand at T0+2+k_len+2(N−1), plus 1 cycle of PE latency, which is within the 2N drain cycles.
- Asynchronous reset mid-job returns to IDLE immediately, with all outputs at their reset values.

## Configuration
- `SYSTOLIC_SEQ_PERF_EN`:
  - When defined, adds output `perf_cycles` (32 bits). It counts cycles with `busy`=1 for the most recent job, clears when a job is accepted, and holds its value after `done` or `abort`. Reset value 0.
  - When undefined, the port and counter are absent and behaviour is otherwise identical.

## Test plan
- Reset check: assert `rst`=0 mid-FEED → all outputs 0 immediately. After release, IDLE with `busy`=0.
- N=4, k_len=3, `start` at T0:
  - `pe_clear` at T0+1.
  - `rd_addr` 0,1,2 at T0+2..T0+4.
  - `a_edge_valid[3]` high T0+6..T0+8.
  - `done` at T0+13.
  - `perf_cycles`=13 when the macro is defined.
- End-to-end with 4×4 PE array, A=all 2, B=all 3, k_len=4 → every PE `result`=24 at `done`. Repeat with A=all −1 → every `result`=0 (ReLU).
- `start` with `k_len`=0 → no state change; `busy` stays 0. `k_len`=20 with K_MAX=16 → exactly 16 `rd_en` cycles.
- `abort` in the second FEED cycle → IDLE next cycle, all edge valids 0, no `done`. A new `start` the following cycle is accepted.
- Back-to-back: `start` again in the cycle after `done` → accepted with a fresh `pe_clear`. A `start` pulsed during DRAIN is ignored.
